cart_bus_ctrl: RTL and testbench

Cartridge bus sequencer sitting directly upstream of the cartridge pin-mapping block. It accepts single-byte read/write requests from the system memory arbiter and drives the cartridge address, strobe, SRAM chip-select and reset lines with fixed setup/strobe/hold timing. It returns read data captured from the cartridge data pins, and produces the write-data/output-enable pair used by the top-level tristate.

---
 rtl/cart_pkg.sv | 21 ++
 rtl/cart_bus_ctrl_if.sv | 14 +
 rtl/cart_rst_gen.sv | 30 +++
 rtl/cart_bus_ctrl.sv | 134 +++++++++++++
 tb/tb_cart_bus_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cart_pkg.sv
// Shared types and constants for the cartridge bus sequencer: FSM state type,
// SRAM window bounds and default phase timing.
package cart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [15:0] SRAM_BASE = 16'hA000;
  localparam logic [15:0] SRAM_LAST = 16'hBFFF;

  localparam int DEF_SETUP_CYC    = 2;
  localparam int DEF_STROBE_CYC   = 4;
  localparam int DEF_HOLD_CYC     = 1;
  localparam int DEF_CART_RST_CYC = 16;

endpackage

// File: rtl/cart_bus_ctrl_if.sv
// Request/response bundle between the system memory arbiter (master) and the
// cartridge bus sequencer (slave).
interface cart_bus_ctrl_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        ack;
  logic [7:0]  rdata;
  logic        busy;

  modport master (output req, we, addr, wdata, input ack, rdata, busy);
  modport slave  (input req, we, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/cart_rst_gen.sv
// Cartridge reset stretcher: holds cart_reset_l low for CART_RST_CYC clocks
// after reset_l is released, then raises ready for the bus sequencer.
module cart_rst_gen
  import cart_pkg::*;
#(
  parameter int CART_RST_CYC = DEF_CART_RST_CYC
) (
  input  logic clock,
  input  logic reset_l,
  output logic cart_reset_l,
  output logic ready
);

  localparam int CW = $clog2(CART_RST_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      cnt   <= '0;
      ready <= 1'b0;
    end else if (!ready) begin
      if (cnt == CW'(CART_RST_CYC - 1)) ready <= 1'b1;
      cnt <= cnt + 1'b1;
    end
  end

  assign cart_reset_l = ready;

endmodule

// File: rtl/cart_bus_ctrl.sv
// Cartridge bus sequencer: one byte access per request with fixed
// setup/strobe/hold phases. Define CART_SRAM_EN to enable the SRAM chip-select decode.
module cart_bus_ctrl
  import cart_pkg::*;
#(
  parameter int SETUP_CYC    = DEF_SETUP_CYC,
  parameter int STROBE_CYC   = DEF_STROBE_CYC,
  parameter int HOLD_CYC     = DEF_HOLD_CYC,
  parameter int CART_RST_CYC = DEF_CART_RST_CYC
) (
  input  logic            clock,
  input  logic            reset_l,
  cart_bus_ctrl_if.slave  bus,
  output logic [15:0]     cart_address,
  output logic            cart_r_enable_l,
  output logic            cart_w_enable_l,
  output logic            cart_cs_sram_l,
  output logic            cart_reset_l,
  input  logic [7:0]      cart_data,
  output logic [7:0]      cart_wdata,
  output logic            cart_data_oe,
  output state_t          state
);

  localparam int MAX_PH = (SETUP_CYC > STROBE_CYC)
                          ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                          : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int CW = $clog2(MAX_PH) + 1;

  state_t        state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last;
  logic          accept;
  logic          ready;
  logic          in_access;
  logic          we_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    rdata_q;

  cart_rst_gen #(.CART_RST_CYC(CART_RST_CYC)) u_rst_gen (
    .clock        (clock),
    .reset_l      (reset_l),
    .cart_reset_l (cart_reset_l),
    .ready        (ready)
  );

  // Handshake: req (with we/addr/wdata) is a level request taken on a clock
  // edge only while IDLE and ready; ack pulses for exactly one cycle in DONE,
  // so a held req restarts after one IDLE cycle.
  assign last = (cnt == '0);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req && ready) begin
          accept    = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = CW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (last) begin
          state_nxt = STROBE;
          cnt_nxt   = CW'(STROBE_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      STROBE: begin
        if (last) begin
          state_nxt = HOLD;
          cnt_nxt   = CW'(HOLD_CYC - 1);
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (last) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
      end
      // Capture on the edge that closes the final strobe cycle.
      if (state == STROBE && last && !we_q) rdata_q <= cart_data;
    end
  end

  assign in_access       = (state == SETUP) || (state == STROBE) || (state == HOLD);
  assign cart_address    = addr_q;
  assign cart_wdata      = wdata_q;
  assign cart_data_oe    = in_access && we_q;
  assign cart_r_enable_l = !((state == STROBE) && !we_q);
  assign cart_w_enable_l = !((state == STROBE) && we_q);

`ifdef CART_SRAM_EN
  logic sram_hit;
  assign sram_hit       = (addr_q >= SRAM_BASE) && (addr_q <= SRAM_LAST);
  assign cart_cs_sram_l = !(sram_hit && in_access);
`else
  assign cart_cs_sram_l = 1'b1;
`endif

  assign bus.ack   = (state == DONE);
  assign bus.rdata = rdata_q;
  assign bus.busy  = !ready || (state != IDLE);

endmodule

// File: tb/tb_cart_bus_ctrl.sv
// Bench for cart_bus_ctrl: reset/stretch checks, a vector table, randomized
// accesses against a timeline model, back-to-back and mid-access reset.
module tb_cart_bus_ctrl;
  import cart_pkg::*;

  localparam int S   = 2;
  localparam int P   = 4;
  localparam int H   = 1;
  localparam int LAT = S + P + H + 1;
  localparam int RST = 16;
`ifdef CART_SRAM_EN
  localparam bit SRAM_EN = 1'b1;
`else
  localparam bit SRAM_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_l = 1'b0;
  logic [15:0] cart_address;
  logic        cart_r_enable_l, cart_w_enable_l, cart_cs_sram_l, cart_reset_l;
  logic [7:0]  cart_data, cart_wdata;
  logic        cart_data_oe;
  state_t      state;

  cart_bus_ctrl_if bus();

  cart_bus_ctrl #(
    .SETUP_CYC(S), .STROBE_CYC(P), .HOLD_CYC(H), .CART_RST_CYC(RST)
  ) dut (
    .clock           (clock),
    .reset_l         (reset_l),
    .bus             (bus),
    .cart_address    (cart_address),
    .cart_r_enable_l (cart_r_enable_l),
    .cart_w_enable_l (cart_w_enable_l),
    .cart_cs_sram_l  (cart_cs_sram_l),
    .cart_reset_l    (cart_reset_l),
    .cart_data       (cart_data),
    .cart_wdata      (cart_wdata),
    .cart_data_oe    (cart_data_oe),
    .state           (state)
  );

  always #5 clock = ~clock;

  int         tests = 0;
  int         fails = 0;
  int         ack_cnt = 0;
  logic [7:0] rd_model = 8'h00;
  logic [7:0] exp_q[$];

  always @(negedge clock) if (bus.ack) ack_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts posedges after reset_l rises until cart_reset_l goes high.
  task automatic wait_stretch(output int edges, output bit busy_ok);
    edges   = 0;
    busy_ok = 1'b1;
    while (!cart_reset_l && edges < 100) begin
      @(posedge clock);
      #1;
      edges++;
      if (!cart_reset_l && !bus.busy) busy_ok = 1'b0;
    end
  endtask

  // One complete access; expectations come from the phase timeline.
  task automatic run_access(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                            input logic [7:0] cdata, input logic [7:0] exp_rd, input string name);
    logic [31:0] a_r, a_w, a_cs, a_oe, a_ack, a_busy;
    logic [31:0] e_r, e_w, e_cs, e_oe, e_ack, e_busy;
    logic        addr_ok, wd_ok, in_rng, act;
    logic [7:0]  rd_at_ack, rd_after;
    {a_r, a_w, a_cs, a_oe, a_ack, a_busy} = '0;
    {e_r, e_w, e_cs, e_oe, e_ack, e_busy} = '0;
    addr_ok   = 1'b1;
    wd_ok     = 1'b1;
    rd_at_ack = 8'hxx;
    in_rng    = (addr >= 16'hA000) && (addr <= 16'hBFFF);
    exp_q.push_back(exp_rd);
    @(negedge clock);
    bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata;
    cart_data = cdata;
    @(posedge clock);
    #1;
    bus.req = 1'b0; bus.we = 1'($urandom); bus.addr = 16'($urandom); bus.wdata = 8'($urandom);
    for (int n = 1; n <= LAT + 1; n++) begin
      @(negedge clock);
      a_r[n]    = !cart_r_enable_l;
      a_w[n]    = !cart_w_enable_l;
      a_cs[n]   = !cart_cs_sram_l;
      a_oe[n]   = cart_data_oe;
      a_ack[n]  = bus.ack;
      a_busy[n] = bus.busy;
      if (cart_address !== addr) addr_ok = 1'b0;
      if (n <= S + P + H && we && cart_wdata !== wdata) wd_ok = 1'b0;
      if (bus.ack) rd_at_ack = bus.rdata;
      act       = (n <= S + P + H);
      e_r[n]    = !we && n > S && n <= S + P;
      e_w[n]    = we && n > S && n <= S + P;
      e_cs[n]   = SRAM_EN && in_rng && act;
      e_oe[n]   = we && act;
      e_ack[n]  = (n == LAT);
      e_busy[n] = (n <= LAT);
    end
    rd_after = bus.rdata;
    check({name, ".rd_strobe"}, a_r, e_r);
    check({name, ".wr_strobe"}, a_w, e_w);
    check({name, ".cs_sram"}, a_cs, e_cs);
    check({name, ".data_oe"}, a_oe, e_oe);
    check({name, ".ack"}, a_ack, e_ack);
    check({name, ".busy"}, a_busy, e_busy);
    check({name, ".addr_held"}, 32'(addr_ok), 32'd1);
    if (we) check({name, ".wdata"}, 32'(wd_ok), 32'd1);
    check({name, ".rdata_ack"}, 32'(rd_at_ack), 32'(exp_q.pop_front()));
    check({name, ".rdata_held"}, 32'(rd_after), 32'(exp_rd));
  endtask

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  cdata;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int edges, acks0, cyc, k;
    int t[2];
    bit busy_ok;
    logic [15:0] ra;
    logic        rwe;
    logic [7:0]  rwd, rcd, rexp;

    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 16'h0; bus.wdata = 8'h0;
    cart_data = 8'h00;

    tbl[0] = '{1'b0, 16'h0134, 8'h00, 8'h5A, 8'h5A};
    tbl[1] = '{1'b1, 16'hA010, 8'hC3, 8'h00, 8'h5A};
    tbl[2] = '{1'b0, 16'hA000, 8'h00, 8'h3C, 8'h3C};
    tbl[3] = '{1'b0, 16'hBFFF, 8'h00, 8'h81, 8'h81};
    tbl[4] = '{1'b1, 16'hC000, 8'h7E, 8'hFF, 8'h81};
    tbl[5] = '{1'b0, 16'h9FFF, 8'h00, 8'h11, 8'h11};

    // Reset values
    repeat (2) @(negedge clock);
    check("rst.address", 32'(cart_address), 32'h0);
    check("rst.r_en", 32'(cart_r_enable_l), 32'd1);
    check("rst.w_en", 32'(cart_w_enable_l), 32'd1);
    check("rst.cs", 32'(cart_cs_sram_l), 32'd1);
    check("rst.cart_reset", 32'(cart_reset_l), 32'd0);
    check("rst.wdata", 32'(cart_wdata), 32'h0);
    check("rst.oe", 32'(cart_data_oe), 32'd0);
    check("rst.ack", 32'(bus.ack), 32'd0);
    check("rst.rdata", 32'(bus.rdata), 32'h0);
    check("rst.busy", 32'(bus.busy), 32'd1);
    check("rst.state", 32'(state), 32'(IDLE));

    // Stretch with a request pending throughout
    @(negedge clock);
    reset_l = 1'b1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0042;
    cart_data = 8'hA5;
    acks0 = ack_cnt;
    wait_stretch(edges, busy_ok);
    check("stretch.len", 32'(edges), 32'(RST));
    check("stretch.busy", 32'(busy_ok), 32'd1);
    check("stretch.no_ack", 32'(ack_cnt), 32'(acks0));
    cyc = 0;
    while (!bus.ack && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    bus.req = 1'b0;
    check("stretch.ack_cycle", 32'(cyc), 32'(LAT + 1));
    check("stretch.rdata", 32'(bus.rdata), 32'hA5);
    rd_model = 8'hA5;
    @(negedge clock);

    // Vector table
    for (int i = 0; i < 6; i++) begin
      run_access(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].cdata, tbl[i].exp_rdata,
                 $sformatf("tbl%0d", i));
      if (!tbl[i].we) rd_model = tbl[i].cdata;
    end

    // Randomized accesses, biased toward the SRAM window edges
    for (int i = 0; i < 24; i++) begin
      rwe = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       ra = 16'($urandom);
        1:       ra = 16'($urandom_range(16'hA000, 16'hBFFF));
        2:       ra = $urandom_range(0, 1) ? 16'h9FFF : 16'hA000;
        default: ra = $urandom_range(0, 1) ? 16'hBFFF : 16'hC000;
      endcase
      rwd  = 8'($urandom);
      rcd  = 8'($urandom);
      rexp = rwe ? rd_model : rcd;
      run_access(rwe, ra, rwd, rcd, rexp, $sformatf("rnd%0d", i));
      rd_model = rexp;
    end

    // Back-to-back reads with req held high
    @(negedge clock);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = 16'h0300;
    cart_data = 8'h42;
    k = 0;
    t[0] = 0; t[1] = 0;
    for (int c = 1; c <= 40 && k < 2; c++) begin
      @(negedge clock);
      if (bus.ack) begin
        t[k] = c;
        check($sformatf("b2b.rdata%0d", k), 32'(bus.rdata), (k == 0) ? 32'h42 : 32'h43);
        k++;
        cart_data = 8'h43;
        if (k == 2) bus.req = 1'b0;
      end
    end
    bus.req = 1'b0;
    check("b2b.ack_count", 32'(k), 32'd2);
    check("b2b.first_ack", 32'(t[0]), 32'(LAT));
    check("b2b.spacing", 32'(t[1] - t[0]), 32'(LAT + 1));
    rd_model = 8'h43;
    @(negedge clock);

    // Reset in the middle of a write strobe
    @(negedge clock);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = 16'hA020; bus.wdata = 8'h66;
    @(posedge clock);
    #1;
    bus.req = 1'b0;
    repeat (4) @(negedge clock);
    check("abort.pre_w_en", 32'(cart_w_enable_l), 32'd0);
    acks0   = ack_cnt;
    reset_l = 1'b0;
    #1;
    check("abort.w_en", 32'(cart_w_enable_l), 32'd1);
    check("abort.r_en", 32'(cart_r_enable_l), 32'd1);
    check("abort.oe", 32'(cart_data_oe), 32'd0);
    check("abort.cs", 32'(cart_cs_sram_l), 32'd1);
    check("abort.ack", 32'(bus.ack), 32'd0);
    check("abort.cart_reset", 32'(cart_reset_l), 32'd0);
    check("abort.state", 32'(state), 32'(IDLE));
    check("abort.address", 32'(cart_address), 32'h0);
    @(negedge clock);
    reset_l = 1'b1;
    wait_stretch(edges, busy_ok);
    check("abort.stretch_len", 32'(edges), 32'(RST));
    repeat (3) @(negedge clock);
    check("abort.no_ack", 32'(ack_cnt), 32'(acks0));
    rd_model = 8'h00;
    run_access(1'b0, 16'h1234, 8'h00, 8'h9C, 8'h9C, "post_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
